// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the system PIO blocks.
// Contents: the register window addresses, the edge-type encodings, the
// debounce counter width helper, and the decoded bus write payload.
package soc_system_pio_pkg;

  localparam int unsigned BUS_W = 32;

  // 2-bit word-address register window
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_UNUSED  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Edge types that can be captured
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Debounce counter width. The result is at least 1 so that a bypassed
  // filter still has a legal vector declaration.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles == 0) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

  // Decoded write strobes for one bus cycle, with the raw write data
  typedef struct packed {
    logic             wr_mask;
    logic             wr_edgecap;
    logic [BUS_W-1:0] wdata;
  } pio_wr_t;

endpackage

// File: rtl/soc_system_pio_debounce.sv
// Single-bit debounce filter for the input PIO.
// A new level at d is accepted on q only after it has held for
// DEBOUNCE_CYCLES consecutive clocks. A shorter pulse is dropped.
// When DEBOUNCE_CYCLES is 0, q is wired straight to d.
// Ports: clk, reset_n (async, active-low), d (synchronised input), q (stable level).
module soc_system_pio_debounce
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign q = d;

      // The clock and reset have no load when the filter is bypassed
      logic unused_bypass;
      assign unused_bypass = &{1'b0, clk, reset_n};
    end else begin : g_filter
      localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          stable;

      // Count how many consecutive cycles d differs from the accepted level.
      // Any return to the accepted level restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt    <= '0;
          stable <= 1'b0;
        end else if (d == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stable <= d;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign q = stable;
    end
  endgenerate

endmodule

// File: rtl/soc_system_input_pio.sv
// Avalon-MM input PIO. in_port is synchronised into clk, optionally
// debounced, and edge-detected. Detected edges go into a sticky EDGECAP
// register. A level irq is raised when any captured edge is also set in
// IRQMASK.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   address, chipselect,
//   write_n, writedata       Avalon-MM slave write side
//   readdata                 combinational read data, zero-extended
//   in_port                  asynchronous external inputs
//   irq                      registered level interrupt
// Register map: 0 DATA (ro), 1 reads 0, 2 IRQMASK (rw), 3 EDGECAP (w1c).
module soc_system_input_pio
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = EDGE_RISING,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] clr;
  pio_wr_t          wr;

  // Two-flop synchroniser for the asynchronous inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // One debounce filter per input bit
  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_db
      soc_system_pio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (s2[i]),
        .q      (stable[i])
      );
    end
  endgenerate

  // Delayed copy of the filtered level for edge detection. Because it resets
  // to 0 together with stable, asserting reset produces no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= stable;
    end
  end

  // Select which transitions count as edges
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_det = ~stable & prev;
      EDGE_ANY:     edge_det = stable ^ prev;
      default:      edge_det = stable & ~prev;
    endcase
  end

  // Decode bus writes
  always_comb begin
    wr       = '0;
    wr.wdata = writedata;
    if (chipselect && !write_n) begin
      wr.wr_mask    = (address == ADDR_IRQMASK);
      wr.wr_edgecap = (address == ADDR_EDGECAP);
    end
  end

  assign clr = wr.wr_edgecap ? wr.wdata[WIDTH-1:0] : '0;

  // Sticky edge capture. A new edge takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else begin
      edgecap <= edge_det | (edgecap & ~clr);
    end
  end

  // Interrupt mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr.wr_mask) begin
      irqmask <= wr.wdata[WIDTH-1:0];
    end
  end

  // irq uses the current register values, so it lags EDGECAP/IRQMASK by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edgecap & irqmask);
    end
  end

  // Read mux, zero latency. It decodes address only and does not look at chipselect.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = BUS_W'(stable);
      ADDR_IRQMASK: readdata = BUS_W'(irqmask);
      ADDR_EDGECAP: readdata = BUS_W'(edgecap);
      default:      readdata = '0;
    endcase
  end

  // Bits of writedata above WIDTH have no load
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wr.wdata};

endmodule
